// File: rtl/spw_pio_fifo_bridge.sv
// rtl/spw_pio_fifo_bridge.sv - Nios PIO to SpaceWire codec host-interface bridge
//
// Purpose:
//   Turns level-driven software strobes (pio_wr_data, pio_rd_data, pio_tick_in)
//   into single-cycle codec handshakes. TX characters are queued in a
//   2**TXFIFO_AW entry FIFO, one RX character is held until software releases
//   it, and time-codes are forwarded in both directions.
//
// Optional feature (macro SPW_BRIDGE_ERRCNT_EN):
//   Adds err_count, a saturating count of dropped TX pushes and of RX releases
//   requested while nothing is held. Cleared only by rst.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pio_data_i [8:0]            TX char {flag, data} from software
//   pio_wr_data                 TX strobe level (rising edge pushes)
//   pio_tx_full                 TX FIFO full
//   pio_data_o [8:0]            held RX char {flag, data}
//   pio_rd_data                 RX ack level (rising edge releases)
//   pio_rx_empty                no RX char held
//   pio_time_in [7:0]           time-code to send
//   pio_tick_in                 send request level (rising edge)
//   pio_time_out [7:0]          last received time-code
//   pio_tick_out                toggles per received time-code
//   spw_txwrite/txflag/txdata   codec TX request and FIFO head
//   spw_txrdy                   codec TX accept
//   spw_rxvalid/rxflag/rxdata   codec RX char
//   spw_rxread                  codec RX pop
//   spw_tick_in, spw_time_in    time-code send pulse and value
//   spw_tick_out, spw_time_out  received time-code pulse and value
//   err_count [7:0]             error counter (SPW_BRIDGE_ERRCNT_EN only)

module spw_pio_fifo_bridge #(
  parameter int TXFIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] pio_data_i,
  input  logic       pio_wr_data,
  output logic       pio_tx_full,
  output logic [8:0] pio_data_o,
  input  logic       pio_rd_data,
  output logic       pio_rx_empty,
  input  logic [7:0] pio_time_in,
  input  logic       pio_tick_in,
  output logic [7:0] pio_time_out,
  output logic       pio_tick_out,
  output logic       spw_txwrite,
  output logic       spw_txflag,
  output logic [7:0] spw_txdata,
  input  logic       spw_txrdy,
  input  logic       spw_rxvalid,
  input  logic       spw_rxflag,
  input  logic [7:0] spw_rxdata,
  output logic       spw_rxread,
  output logic       spw_tick_in,
  output logic [7:0] spw_time_in,
  input  logic       spw_tick_out,
  input  logic [7:0] spw_time_out
`ifdef SPW_BRIDGE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int DEPTH = 1 << TXFIFO_AW;
  localparam logic [TXFIFO_AW:0] DEPTH_C = (TXFIFO_AW + 1)'(DEPTH);

  // Edge-detect history; reset to 1 so a strobe held high through reset
  // must drop low before it can count again.
  logic wr_prev_q, rd_prev_q, tick_prev_q;
  logic wr_edge, rd_edge, tick_edge;

  assign wr_edge   = pio_wr_data & ~wr_prev_q;
  assign rd_edge   = pio_rd_data & ~rd_prev_q;
  assign tick_edge = pio_tick_in & ~tick_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prev_q   <= 1'b1;
      rd_prev_q   <= 1'b1;
      tick_prev_q <= 1'b1;
    end else begin
      wr_prev_q   <= pio_wr_data;
      rd_prev_q   <= pio_rd_data;
      tick_prev_q <= pio_tick_in;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [8:0]           mem_q [DEPTH];
  logic [TXFIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [TXFIFO_AW:0]   count_q, count_d;
  logic                 push, pop, fifo_full, fifo_nempty;

  assign fifo_full   = (count_q == DEPTH_C);
  assign fifo_nempty = (count_q != '0);
  // Fullness is judged before this cycle's pop, so a push into a full FIFO
  // is dropped even when the head leaves in the same cycle.
  assign push        = wr_edge & ~fifo_full;
  assign pop         = fifo_nempty & spw_txrdy;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= pio_data_i;
  end

  assign pio_tx_full               = fifo_full;
  assign spw_txwrite               = fifo_nempty;
  assign {spw_txflag, spw_txdata}  = fifo_nempty ? mem_q[rptr_q] : 9'h000;

  // ---------------------------------------------------------------- RX hold
  logic       rx_held_q, rx_held_d;
  logic [8:0] rx_data_q, rx_data_d;

  // Capture depends on the registered hold flag, so after a release the
  // next char is taken one cycle later at the earliest.
  assign spw_rxread = spw_rxvalid & ~rx_held_q;

  always_comb begin
    rx_held_d = rx_held_q;
    rx_data_d = rx_data_q;
    if (spw_rxread) begin
      rx_held_d = 1'b1;
      rx_data_d = {spw_rxflag, spw_rxdata};
    end else if (rd_edge && rx_held_q) begin
      rx_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_held_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      rx_held_q <= rx_held_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign pio_data_o   = rx_data_q;
  assign pio_rx_empty = ~rx_held_q;

  // ---------------------------------------------------------------- time-codes
  logic       tick_in_q;
  logic [7:0] time_in_q, time_out_q;
  logic       tick_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_in_q  <= 1'b0;
      time_in_q  <= '0;
      time_out_q <= '0;
      tick_out_q <= 1'b0;
    end else begin
      tick_in_q <= tick_edge;
      if (tick_edge) time_in_q <= pio_time_in;
      if (spw_tick_out) begin
        time_out_q <= spw_time_out;
        tick_out_q <= ~tick_out_q;
      end
    end
  end

  assign spw_tick_in  = tick_in_q;
  assign spw_time_in  = time_in_q;
  assign pio_time_out = time_out_q;
  assign pio_tick_out = tick_out_q;

`ifdef SPW_BRIDGE_ERRCNT_EN
  // ---------------------------------------------------------------- errors
  logic       drop, rd_err;
  logic [7:0] err_q, err_d;
  logic [8:0] err_sum;

  assign drop    = wr_edge & fifo_full;
  assign rd_err  = rd_edge & ~rx_held_q;
  assign err_sum = {1'b0, err_q} + 9'(drop) + 9'(rd_err);
  assign err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_spw_pio_fifo_bridge.sv
// tb/tb_spw_pio_fifo_bridge.sv - self-checking bench for spw_pio_fifo_bridge

module tb_spw_pio_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] pio_data_i;
  logic       pio_wr_data;
  logic       pio_tx_full;
  logic [8:0] pio_data_o;
  logic       pio_rd_data;
  logic       pio_rx_empty;
  logic [7:0] pio_time_in;
  logic       pio_tick_in;
  logic [7:0] pio_time_out;
  logic       pio_tick_out;
  logic       spw_txwrite;
  logic       spw_txflag;
  logic [7:0] spw_txdata;
  logic       spw_txrdy;
  logic       spw_rxvalid;
  logic       spw_rxflag;
  logic [7:0] spw_rxdata;
  logic       spw_rxread;
  logic       spw_tick_in;
  logic [7:0] spw_time_in;
  logic       spw_tick_out;
  logic [7:0] spw_time_out;
`ifdef SPW_BRIDGE_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spw_pio_fifo_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .pio_data_i   (pio_data_i),
    .pio_wr_data  (pio_wr_data),
    .pio_tx_full  (pio_tx_full),
    .pio_data_o   (pio_data_o),
    .pio_rd_data  (pio_rd_data),
    .pio_rx_empty (pio_rx_empty),
    .pio_time_in  (pio_time_in),
    .pio_tick_in  (pio_tick_in),
    .pio_time_out (pio_time_out),
    .pio_tick_out (pio_tick_out),
    .spw_txwrite  (spw_txwrite),
    .spw_txflag   (spw_txflag),
    .spw_txdata   (spw_txdata),
    .spw_txrdy    (spw_txrdy),
    .spw_rxvalid  (spw_rxvalid),
    .spw_rxflag   (spw_rxflag),
    .spw_rxdata   (spw_rxdata),
    .spw_rxread   (spw_rxread),
    .spw_tick_in  (spw_tick_in),
    .spw_time_in  (spw_time_in),
    .spw_tick_out (spw_tick_out),
    .spw_time_out (spw_time_out)
`ifdef SPW_BRIDGE_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: TX FIFO as a queue, RX hold as a flag, edges from levels.
  logic [8:0] mq[$];
  bit         m_held, m_pw, m_pr, m_pt, m_tick_in, m_tick_out;
  logic [8:0] m_data;
  logic [7:0] m_time_in, m_time_out;
  int         m_err;

  task automatic model_reset();
    mq.delete();
    m_held = 0; m_data = '0;
    m_pw = 1; m_pr = 1; m_pt = 1;
    m_tick_in = 0; m_time_in = '0; m_tick_out = 0; m_time_out = '0;
    m_err = 0;
  endtask

  task automatic model_step();
    bit ew, er, et, was_full, was_held;
    if (rst) begin
      model_reset();
      return;
    end
    ew = pio_wr_data && !m_pw;
    er = pio_rd_data && !m_pr;
    et = pio_tick_in && !m_pt;
    m_pw = pio_wr_data; m_pr = pio_rd_data; m_pt = pio_tick_in;
    was_full = (mq.size() == 8);
    if (mq.size() != 0 && spw_txrdy) void'(mq.pop_front());
    if (ew) begin
      if (!was_full) mq.push_back(pio_data_i);
      else m_err++;
    end
    was_held = m_held;
    if (spw_rxvalid && !was_held) begin
      m_held = 1; m_data = {spw_rxflag, spw_rxdata};
    end else if (er && was_held) begin
      m_held = 0;
    end
    if (er && !was_held) m_err++;
    if (m_err > 255) m_err = 255;
    m_tick_in = et;
    if (et) m_time_in = pio_time_in;
    if (spw_tick_out) begin
      m_time_out = spw_time_out;
      m_tick_out = !m_tick_out;
    end
  endtask

  initial begin
    rst = 1; pio_data_i = '0; pio_wr_data = 0; pio_rd_data = 0;
    pio_time_in = '0; pio_tick_in = 0; spw_txrdy = 0; spw_rxvalid = 0;
    spw_rxflag = 0; spw_rxdata = '0; spw_tick_out = 0; spw_time_out = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_txwrite", 16'(spw_txwrite), 16'h0);
    chk("rst_full", 16'(pio_tx_full), 16'h0);
    chk("rst_rx_empty", 16'(pio_rx_empty), 16'h1);
    chk("rst_data_o", 16'(pio_data_o), 16'h0);
    chk("rst_tick_in", 16'(spw_tick_in), 16'h0);
    chk("rst_tick_out", 16'(pio_tick_out), 16'h0);
    chk("rst_rxread", 16'(spw_rxread), 16'h0);
    rst = 0;
    cyc();

    // 1: single char, one-cycle txwrite
    spw_txrdy = 1; pio_data_i = 9'h1A5; pio_wr_data = 1;
    #1 chk("t1_txwrite_pre", 16'(spw_txwrite), 16'h0);
    cyc();
    chk("t1_txwrite", 16'(spw_txwrite), 16'h1);
    chk("t1_head", 16'({spw_txflag, spw_txdata}), 16'h1A5);
    cyc();
    chk("t1_txwrite_off", 16'(spw_txwrite), 16'h0);
    pio_wr_data = 0;
    cyc();

    // 2: fill, drop, drain
    spw_txrdy = 0;
    for (int i = 1; i <= 9; i++) begin
      pio_data_i = 9'(i); pio_wr_data = 1;
      cyc();
      chk($sformatf("t2_full_%0d", i), 16'(pio_tx_full), (i >= 8) ? 16'h1 : 16'h0);
      pio_wr_data = 0;
      cyc();
    end
`ifdef SPW_BRIDGE_ERRCNT_EN
    chk("t2_err", 16'(err_count), 16'h1);
`endif
    spw_txrdy = 1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("t2_txwrite_%0d", k), 16'(spw_txwrite), 16'h1);
      chk($sformatf("t2_head_%0d", k), 16'({spw_txflag, spw_txdata}), 16'(k));
      cyc();
      if (k == 1) chk("t2_full_clear", 16'(pio_tx_full), 16'h0);
    end
    chk("t2_drained", 16'(spw_txwrite), 16'h0);

    // 3: RX capture and stall
    spw_rxvalid = 1; spw_rxflag = 0; spw_rxdata = 8'h3C;
    #1 chk("t3_rxread", 16'(spw_rxread), 16'h1);
    cyc();
    chk("t3_data", 16'(pio_data_o), 16'h03C);
    chk("t3_empty", 16'(pio_rx_empty), 16'h0);
    chk("t3_rxread_stall", 16'(spw_rxread), 16'h0);
    spw_rxflag = 1; spw_rxdata = 8'h55;
    cyc();
    chk("t3_stall_data", 16'(pio_data_o), 16'h03C);
    chk("t3_stall_rxread", 16'(spw_rxread), 16'h0);
    pio_rd_data = 1;
    cyc();
    chk("t3_released", 16'(pio_rx_empty), 16'h1);
    chk("t3_keep_data", 16'(pio_data_o), 16'h03C);
    chk("t3_rxread2", 16'(spw_rxread), 16'h1);
    cyc();
    chk("t3_data2", 16'(pio_data_o), 16'h155);
    chk("t3_empty2", 16'(pio_rx_empty), 16'h0);
    spw_rxvalid = 0; pio_rd_data = 0;
    cyc();

    // 4: rd edge while empty
    pio_rd_data = 1; cyc(); pio_rd_data = 0; cyc();
    pio_rd_data = 1; cyc();
    chk("t4_data", 16'(pio_data_o), 16'h155);
    chk("t4_empty", 16'(pio_rx_empty), 16'h1);
    chk("t4_rxread", 16'(spw_rxread), 16'h0);
`ifdef SPW_BRIDGE_ERRCNT_EN
    chk("t4_err", 16'(err_count), 16'h2);
`endif
    pio_rd_data = 0;

    // 5: time-codes
    pio_time_in = 8'h2F; pio_tick_in = 1;
    #1 chk("t5_tick_pre", 16'(spw_tick_in), 16'h0);
    cyc();
    chk("t5_tick", 16'(spw_tick_in), 16'h1);
    chk("t5_time", 16'(spw_time_in), 16'h2F);
    cyc();
    chk("t5_tick_once", 16'(spw_tick_in), 16'h0);
    pio_tick_in = 0; spw_time_out = 8'h15; spw_tick_out = 1;
    cyc();
    chk("t5_time_out", 16'(pio_time_out), 16'h15);
    chk("t5_toggle", 16'(pio_tick_out), 16'h1);
    spw_tick_out = 0;
    cyc();
    chk("t5_toggle_hold", 16'(pio_tick_out), 16'h1);

    // 6: reset mid-operation
    spw_txrdy = 0;
    for (int i = 0; i < 5; i++) begin
      pio_data_i = 9'(8'h40 + i); pio_wr_data = 1; cyc(); pio_wr_data = 0; cyc();
    end
    chk("t6_queued", 16'(spw_txwrite), 16'h1);
    pio_wr_data = 1; rst = 1;
    cyc();
    rst = 0;
    chk("t6_txwrite", 16'(spw_txwrite), 16'h0);
    chk("t6_full", 16'(pio_tx_full), 16'h0);
    chk("t6_tick_out", 16'(pio_tick_out), 16'h0);
    cyc();
    chk("t6_no_push", 16'(spw_txwrite), 16'h0);
    pio_wr_data = 0; cyc();
    pio_data_i = 9'h0EE; pio_wr_data = 1; cyc();
    chk("t6_push", 16'(spw_txwrite), 16'h1);
    chk("t6_head", 16'({spw_txflag, spw_txdata}), 16'h0EE);

    // Randomized traffic against the reference model
    rst = 1; pio_wr_data = 0; cyc();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 79) == 0);
      pio_wr_data  = 1'($urandom);
      pio_data_i   = 9'($urandom);
      spw_txrdy    = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      spw_rxvalid  = 1'($urandom);
      spw_rxflag   = 1'($urandom);
      spw_rxdata   = 8'($urandom);
      pio_rd_data  = 1'($urandom);
      pio_tick_in  = 1'($urandom);
      pio_time_in  = 8'($urandom);
      spw_tick_out = ($urandom_range(0, 3) == 0);
      spw_time_out = 8'($urandom);
      #1;
      chk("r_txwrite", 16'(spw_txwrite), 16'(mq.size() != 0));
      if (mq.size() != 0) chk("r_head", 16'({spw_txflag, spw_txdata}), 16'(mq[0]));
      chk("r_rxread", 16'(spw_rxread), 16'(spw_rxvalid && !m_held));
      model_step();
      cyc();
      chk("r_full", 16'(pio_tx_full), 16'(mq.size() == 8));
      chk("r_empty", 16'(pio_rx_empty), 16'(!m_held));
      chk("r_data_o", 16'(pio_data_o), 16'(m_data));
      chk("r_tick_in", 16'(spw_tick_in), 16'(m_tick_in));
      chk("r_time_in", 16'(spw_time_in), 16'(m_time_in));
      chk("r_tick_out", 16'(pio_tick_out), 16'(m_tick_out));
      chk("r_time_out", 16'(pio_time_out), 16'(m_time_out));
`ifdef SPW_BRIDGE_ERRCNT_EN
      chk("r_err", 16'(err_count), 16'(m_err));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
